// File: rtl/alu_pkg.sv
// Shared opcode, compare-flag and multiplier-state definitions for the execute-stage ALU.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

  // 4-bit opcodes as decoded by issue; 12..15 are unimplemented.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_LD  = 4'd1;
  localparam logic [3:0] ALU_ST  = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_MUL = 4'd4;
  localparam logic [3:0] ALU_CMP = 4'd5;
  localparam logic [3:0] ALU_MOV = 4'd6;
  localparam logic [3:0] ALU_OR  = 4'd7;
  localparam logic [3:0] ALU_AND = 4'd8;
  localparam logic [3:0] ALU_NOT = 4'd9;
  localparam logic [3:0] ALU_LSL = 4'd10;
  localparam logic [3:0] ALU_LSR = 4'd11;

  // Architectural compare flag encodings (unsigned compare of A against B).
  localparam logic [1:0] CMP_LT = 2'h0;
  localparam logic [1:0] CMP_EQ = 2'h1;
  localparam logic [1:0] CMP_GT = 2'h2;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > ALU_LSR;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative multiplier: low DATA_W bits of a*b, one slice of b consumed per cycle.
// Latency: product valid (done=1) MUL_CYCLES-1 cycles after start; MUL_CYCLES=1 is combinational.
// Backpressure: stall holds the finished product and counter until released.
// Ports: clk, rst_n (sync, active low); start loads a new op; stall freezes a finished op;
//   a/b operands (must stay stable while busy); done/product results.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int STEP  = (DATA_W + MUL_CYCLES - 1) / MUL_CYCLES;
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MUL_CYCLES - 1);
  localparam logic [DATA_W-1:0] ONES       = '1;
  localparam logic [DATA_W-1:0] SLICE_MASK = ~(ONES << STEP);

  mul_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] slice;
  logic [31:0]       shamt;

  // The current slice's partial product is added combinationally, so on the
  // last count the output already carries the complete product.
  always_comb begin
    shamt   = 32'(cnt) * 32'(STEP);
    slice   = (b >> shamt) & SLICE_MASK;
    product = acc + ((a * slice) << shamt);
  end

  assign done = (state == MUL_BUSY) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MUL_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else if (start) begin
      state <= MUL_BUSY;
      cnt   <= '0;
      acc   <= '0;
    end else if (state == MUL_BUSY) begin
      if (cnt != CNT_LAST) begin
        cnt <= cnt + CNT_W'(1);
        acc <= product;
      end else if (!stall) begin
        // Finished product leaves with S1 this cycle.
        state <= MUL_IDLE;
        cnt   <= '0;
        acc   <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage handshaked execute ALU: S1 holds the accepted op, S2 holds the result for writeback.
// Latency: accept at N -> out_valid at N+2 (N+1+MUL_CYCLES for MUL); 1 op/cycle otherwise.
// Backpressure: out_* held while out_valid & !out_ready; S1 then holds and in_ready drops.
// Ports: clk, rst_n (sync, active low); in_* issue side (valid/ready, op, operands, imm, tag);
//   out_* writeback side (valid/ready, result, tag, illegal); cmp_flag from the last CMP into S2.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int IMM_W      = 5,
  parameter int INSTR_W    = 16,
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [DATA_W-1:0]  in_op1,
  input  logic [DATA_W-1:0]  in_op2,
  input  logic [IMM_W-1:0]   in_imm,
  input  logic               in_use_imm,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_illegal,
  output logic [1:0]         cmp_flag
);

  localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

  typedef struct packed {
    logic [3:0]         op;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [INSTR_W-1:0] instr;
  } s1_t;

  s1_t               s1_q;
  logic              s1_vld;
  logic              s2_vld;
  logic              s1_done;
  logic              s2_free;
  logic              s1_move;
  logic              accept;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] b_sel;
  logic [DATA_W-1:0] res;
  logic [1:0]        cmp_next;

  assign b_sel   = in_use_imm ? {{(DATA_W-IMM_W){1'b0}}, in_imm} : in_op2;
  assign s1_done = s1_vld && ((s1_q.op != ALU_MUL) || mul_done);
  assign s2_free = !s2_vld || out_ready;
  assign s1_move = s1_done && s2_free;
  assign in_ready = rst_n && (!s1_vld || s1_move);
  assign accept   = in_valid && in_ready;
  assign out_valid = s2_vld;

  alu_mul_iter #(
    .DATA_W     (DATA_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && (in_op == ALU_MUL)),
    .stall   (!s2_free),
    .a       (s1_q.a),
    .b       (s1_q.b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    res = '0;
    case (s1_q.op)
      ALU_ADD, ALU_LD, ALU_ST: res = s1_q.a + s1_q.b;
      ALU_SUB: res = s1_q.a - s1_q.b;
      ALU_MUL: res = mul_product;
      ALU_CMP: res = {{(DATA_W-1){1'b0}}, (s1_q.a == s1_q.b)};
      ALU_MOV: res = s1_q.b;
      ALU_OR:  res = s1_q.a | s1_q.b;
      ALU_AND: res = s1_q.a & s1_q.b;
      ALU_NOT: res = ~s1_q.a;
      // Oversized shift amounts clear the result rather than wrapping.
      ALU_LSL: res = (s1_q.b >= SHIFT_LIM) ? '0 : (s1_q.a << s1_q.b);
      ALU_LSR: res = (s1_q.b >= SHIFT_LIM) ? '0 : (s1_q.a >> s1_q.b);
      default: res = '0;
    endcase
  end

  always_comb begin
    cmp_next = CMP_LT;
    if (s1_q.a == s1_q.b)     cmp_next = CMP_EQ;
    else if (s1_q.a > s1_q.b) cmp_next = CMP_GT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld      <= 1'b0;
      s1_q        <= '0;
      s2_vld      <= 1'b0;
      out_result  <= '0;
      out_instr   <= '0;
      out_illegal <= 1'b0;
      cmp_flag    <= 2'h0;
    end else begin
      // S1: a new accept takes priority; it can coincide with the old op moving out.
      if (accept) begin
        s1_vld     <= 1'b1;
        s1_q.op    <= in_op;
        s1_q.a     <= in_op1;
        s1_q.b     <= b_sel;
        s1_q.instr <= in_instr;
      end else if (s1_move) begin
        s1_vld <= 1'b0;
      end

      // S2: reload on move (also covers drain+reload in the same cycle).
      if (s1_move) begin
        s2_vld      <= 1'b1;
        out_result  <= res;
        out_instr   <= s1_q.instr;
        out_illegal <= op_is_illegal(s1_q.op);
        if (s1_q.op == ALU_CMP) cmp_flag <= cmp_next;
      end else if (out_ready) begin
        s2_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  localparam int DW = 16;
  localparam int IW = 5;
  localparam int TW = 16;
  localparam int MC = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd9;
  localparam logic [3:0] OP_LSL = 4'd10;
  localparam logic [3:0] OP_LSR = 4'd11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [DW-1:0] in_op1;
  logic [DW-1:0] in_op2;
  logic [IW-1:0] in_imm;
  logic          in_use_imm;
  logic [TW-1:0] in_instr;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_instr;
  logic          out_illegal;
  logic [1:0]    cmp_flag;

  alu_pipe #(
    .DATA_W     (DW),
    .IMM_W      (IW),
    .INSTR_W    (TW),
    .MUL_CYCLES (MC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_op1      (in_op1),
    .in_op2      (in_op2),
    .in_imm      (in_imm),
    .in_use_imm  (in_use_imm),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_instr   (out_instr),
    .out_illegal (out_illegal),
    .cmp_flag    (cmp_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic          ill;
    logic [1:0]    flag;
    int            acc;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic [1:0]    model_flag = 2'h0;
  logic [TW-1:0] tag_ctr = '0;
  int            ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model straight from the opcode table, using 32-bit arithmetic then truncating.
  function automatic logic [DW-1:0] ref_result(input logic [3:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    int unsigned ua;
    int unsigned ub;
    int unsigned r;
    ua = a;
    ub = b;
    case (op)
      4'd0, 4'd1, 4'd2: r = ua + ub;
      4'd3:  r = ua - ub;
      4'd4:  r = ua * ub;
      4'd5:  r = (ua == ub) ? 1 : 0;
      4'd6:  r = ub;
      4'd7:  r = ua | ub;
      4'd8:  r = ua & ub;
      4'd9:  r = ~ua;
      4'd10: r = (ub >= DW) ? 0 : (ua << ub);
      4'd11: r = (ub >= DW) ? 0 : (ua >> ub);
      default: r = 0;
    endcase
    return r[DW-1:0];
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [IW-1:0] imm, input logic use_imm, input int lat);
    logic [DW-1:0] bb;
    exp_t          e;
    int            t;
    bb = use_imm ? DW'(imm) : b;
    in_valid   = 1'b1;
    in_op      = op;
    in_op1     = a;
    in_op2     = b;
    in_imm     = imm;
    in_use_imm = use_imm;
    in_instr   = tag_ctr;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 500) begin
        n_checks++;
        $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 500 cycles (tag %0h)", tag_ctr);
        in_valid = 1'b0;
        return;
      end
    end
    if (op == OP_CMP) model_flag = (a == bb) ? 2'h1 : ((a > bb) ? 2'h2 : 2'h0);
    e.res  = ref_result(op, a, bb);
    e.tag  = tag_ctr;
    e.ill  = (op >= 4'd12);
    e.flag = model_flag;
    e.acc  = cyc;
    e.lat  = lat;
    sb.push_back(e);
    tag_ctr = tag_ctr + 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // out_ready driver (sole writer of out_ready).
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output transfer, and checks hold-stability.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] p_res;
    logic [TW-1:0] p_tag;
    logic          p_ill;
    exp_t          e;
    prev_stall = 1'b0;
    p_res = '0;
    p_tag = '0;
    p_ill = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_result", out_result, p_res);
        chk("hold_tag", out_instr, p_tag);
        chk("hold_illegal", out_illegal, p_ill);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: out_valid=1 result %0h tag %0h, required no output", out_result, out_instr);
        end else if (out_ready) begin
          e = sb.pop_front();
          chk("result", out_result, e.res);
          chk("tag", out_instr, e.tag);
          chk("illegal", out_illegal, e.ill);
          chk("cmp_flag", cmp_flag, e.flag);
          if (e.lat != 0) chk("latency", cyc - e.acc, e.lat);
        end
      end
      prev_stall = out_valid && !out_ready;
      p_res = out_result;
      p_tag = out_instr;
      p_ill = out_illegal;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_op = '0;
    in_op1 = '0;
    in_op2 = '0;
    in_imm = '0;
    in_use_imm = 1'b0;
    in_instr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_low", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_cmp_flag", cmp_flag, 0);
    @(posedge clk);
    #1;

    // Set a nonzero flag so reset has something to clear.
    issue(OP_CMP, 16'd9, 16'd3, 5'd0, 1'b0, 2);
    wait_drain();

    // Reset mid-MUL: no stale result may surface afterwards.
    issue(OP_MUL, 16'h0102, 16'h0003, 5'd0, 1'b0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    model_flag = 2'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mulrst_out_valid", out_valid, 0);
    chk("mulrst_cmp_flag", cmp_flag, 0);
    chk("mulrst_in_ready", in_ready, 1);
    repeat (8) @(posedge clk);
    #1;

    // Back-to-back ops, one per cycle.
    issue(OP_ADD, 16'd3, 16'd4, 5'd0, 1'b0, 2);
    issue(OP_SUB, 16'd2, 16'd5, 5'd0, 1'b0, 2);
    issue(OP_OR, 16'h0100, 16'hAAAA, 5'h1F, 1'b1, 2);
    wait_drain();

    // MUL then ADD; issue must be blocked while the multiplier iterates.
    issue(OP_MUL, 16'h0102, 16'h0003, 5'd0, 1'b0, 1 + MC);
    for (int i = 0; i < MC - 1; i++) begin
      @(negedge clk);
      chk("mul_busy_in_ready", in_ready, 0);
    end
    issue(OP_ADD, 16'd1, 16'd1, 5'd0, 1'b0, 2);
    wait_drain();

    // Compares, then a non-compare must leave the flag alone.
    issue(OP_CMP, 16'd5, 16'd5, 5'd0, 1'b0, 2);
    issue(OP_CMP, 16'd9, 16'd3, 5'd0, 1'b0, 2);
    issue(OP_CMP, 16'd2, 16'd7, 5'd0, 1'b0, 2);
    issue(OP_NOT, 16'h00FF, 16'd0, 5'd0, 1'b0, 2);
    wait_drain();

    // Backpressure: 3 ops offered against a stalled writeback.
    ready_mode = 0;
    fork
      begin
        issue(OP_ADD, 16'd10, 16'd20, 5'd0, 1'b0, 0);
        issue(OP_SUB, 16'd50, 16'd8, 5'd0, 1'b0, 0);
        issue(OP_OR, 16'hF000, 16'h000F, 5'd0, 1'b0, 0);
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_accepted", sb.size(), 2);
        chk("bp_in_ready", in_ready, 0);
        ready_mode = 1;
      end
    join
    wait_drain();

    // Edge cases.
    issue(OP_LSL, 16'h0001, 16'd15, 5'd0, 1'b0, 2);
    issue(OP_LSL, 16'h0001, 16'd16, 5'd0, 1'b0, 2);
    issue(OP_LSR, 16'hFFFF, 16'd1, 5'd20, 1'b1, 2);
    issue(OP_ADD, 16'hFFFF, 16'h0001, 5'd0, 1'b0, 2);
    issue(4'd13, 16'h1234, 16'h5678, 5'd0, 1'b0, 2);
    wait_drain();

    // Randomized traffic with random writeback stalls.
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      logic [3:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [IW-1:0] imm;
      logic          ui;
      int            gap;
      op  = 4'($urandom_range(0, 15));
      a   = DW'($urandom);
      b   = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 20)) : DW'($urandom);
      imm = IW'($urandom);
      ui  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      issue(op, a, b, imm, ui, 0);
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    ready_mode = 1;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
